clock_enable_bank: RTL and testbench
====================================

# clock_enable_bank

Parametrised, single-clock successor to the fixed-frequency clock generator: produces P_CHANNELS independently programmable clock-enable tick streams from the bus clock. It replaces per-frequency PLL outputs for low-rate consumers (display, DPS, timers). Every consumer stays in one clock domain and qualifies its logic with a tick. Each channel has a run-time divisor, an enable and a lock indication, and divisor changes are applied without glitches.

## Interface
- P_CHANNELS, 4: number of channels, range 1..16.
- P_DIV_WIDTH, 16: divisor and counter width, range 2..32.
- P_RESET_DIV, 0: divisor loaded into every channel at reset.
- iCLOCK  in  1  bus clock; all state is on its rising edge.
- iRESET  in  1  asynchronous, active-high reset.
- iCONF_REQ  in  1  single-cycle configuration write strobe.
- iCONF_CH  in  CW  target channel; CW = max(1, $clog2(P_CHANNELS)).
- iCONF_DIV  in  P_DIV_WIDTH  new divisor D; tick period is D+1 cycles.
- iCH_EN  in  P_CHANNELS  per-channel run enable, level sensitive.
- oTICK  out  P_CHANNELS  one-cycle enable pulse per period.
- oLOCKED  out  P_CHANNELS  channel has produced at least one full period since enable.
- oPENDING  out  P_CHANNELS  a divisor write is waiting for a period boundary.
- oALL_LOCKED  out  1  at least one channel is enabled, and every enabled channel is locked.
- oTOGGLE  out  P_CHANNELS  50% duty square wave (present only with the macro).

## Operation
- Per-channel state: cnt, div_act, div_pend, pend flag, lock flag, toggle.
- The FSM has three states:
  - OFF: iCH_EN=0.
  - SYNC: enabled, no tick yet.
  - LOCK: at least one tick since enable.
- OFF→SYNC on iCH_EN=1. SYNC→LOCK on the first tick. Any state→OFF when iCH_EN=0.
- In OFF: cnt=0, oTICK=0, oLOCKED=0, toggle=0.
- In SYNC/LOCK: cnt increments each cycle. When cnt==div_act, the tick fires and cnt wraps to 0.
- Config write with iCONF_CH < P_CHANNELS:
  - Channel enabled: div_pend is loaded and pend is set.
  - Channel OFF: div_act is loaded directly and pend is not set.
- iCONF_CH >= P_CHANNELS: the write is ignored.
- Pending divisor: at the wrap, div_act←div_pend and pend clears. The period ending at that wrap uses the old divisor.
- A second write while pend is set overwrites div_pend; the last write wins.
- A write coinciding with a wrap is held pending for the following wrap.
- A divisor change does not drop oLOCKED.
- D=0: a tick every cycle; oTICK stays high continuously while enabled.
- D=2^W-1: period 2^W cycles; the counter must not overflow.
- Disabling a channel discards any pending divisor, and pend clears. div_act is retained.

## Timing
- All outputs are registered.
- Reset values:
  - oTICK=0, oLOCKED=0, oPENDING=0, oALL_LOCKED=0, oTOGGLE=0.
  - div_act=P_RESET_DIV, cnt=0.
- Enable sampled high at edge t: the first oTICK is high in cycle t+D+1, then every D+1 cycles.
- oLOCKED rises in the same cycle as the first oTICK.
- oPENDING rises the cycle after the write and falls the cycle after the applying wrap.
- oALL_LOCKED lags the per-channel flags by one cycle.
- iCH_EN low at edge t: oTICK and oLOCKED are 0 from cycle t+1.
- Reset asserted mid-operation forces all outputs to their reset values immediately. Operation resumes on the first edge after deassertion.

## Configuration
- Macro: CLOCK_ENABLE_BANK_TOGGLE_EN.
- Defined:
  - oTOGGLE exists.
  - Each channel's toggle inverts on every tick, giving period 2(D+1) and exact 50% duty.
  - Toggle is 0 in OFF and at reset.
- Undefined: the port and its flops are absent; all other behaviour is identical.

## Structure
- The shared package clock_enable_pkg holds:
  - The state encoding constants CEB_OFF, CEB_SYNC, CEB_LOCK.
  - The channel-index width function.
  - The parameter range limits.
- Sub-module clock_enable_channel holds one channel's counter, divisor registers, FSM and toggle. The top module decodes the config write, instantiates channels in a generate loop and reduces oALL_LOCKED.

## Test plan
- Reset, then enable channel 0 with D=4 → oTICK[0] at 5, 10, 15 cycles after enable; oLOCKED[0] high from the first tick.
- Channel 1 at D=3, write D=7 mid-period → the current period stays 4 cycles, then periods are 8; oPENDING high until the wrap.
- Two writes (D=9, then D=2) in one period → only D=2 is applied; the write to iCONF_CH=P_CHANNELS is ignored.
- D=0 → oTICK continuously high. D=2^W-1 → period 2^W cycles, with no early tick.
- Enable channels 0 and 2 at D=1 and D=6 → oALL_LOCKED rises one cycle after channel 2 locks. Disable channel 2 → it remains high. Disable all → it drops.
- Assert iRESET mid-period with a write pending → all outputs are 0 at once, and div_act returns to P_RESET_DIV. With the macro defined, oTOGGLE at D=2 has period 6 with 3 cycles high.

Source files
------------

// File: rtl/clock_enable_pkg.sv
// rtl/clock_enable_pkg.sv - shared definitions for the clock-enable bank
// Purpose: channel FSM state encoding, channel-index width helper and the
//          legal parameter ranges used by clock_enable_bank and
//          clock_enable_channel.
// Ports:   none (package).
package clock_enable_pkg;

   localparam int CEB_MIN_CHANNELS  = 1;
   localparam int CEB_MAX_CHANNELS  = 16;
   localparam int CEB_MIN_DIV_WIDTH = 2;
   localparam int CEB_MAX_DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      CEB_OFF  = 2'd0,
      CEB_SYNC = 2'd1,
      CEB_LOCK = 2'd2
   } ceb_state_e;

   // A single channel still needs a one-bit select field.
   function automatic int ceb_ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clock_enable_channel.sv
// rtl/clock_enable_channel.sv - one programmable clock-enable tick channel
// Purpose: counter, active/pending divisor registers, OFF/SYNC/LOCK FSM and
//          optional square-wave toggle (CLOCK_ENABLE_BANK_TOGGLE_EN).
// Ports:   clk_i, rst_i    clock, asynchronous active-high reset
//          en_i            run enable (level)
//          wr_i, div_i     divisor write strobe and value
//          tick_o          one-cycle tick per period of div_act+1 cycles
//          locked_o        at least one tick since enable
//          pending_o       divisor write waiting for the next wrap
//          active_o        channel is not OFF
//          toggle_o        50% duty square wave (macro only)
module clock_enable_channel
   import clock_enable_pkg::*;
#(
   parameter int          P_DIV_WIDTH = 16,
   parameter int unsigned P_RESET_DIV = 0
)
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   en_i,
   input  logic                   wr_i,
   input  logic [P_DIV_WIDTH-1:0] div_i,
   output logic                   tick_o,
   output logic                   locked_o,
   output logic                   pending_o,
   output logic                   active_o
`ifdef CLOCK_ENABLE_BANK_TOGGLE_EN
   ,
   output logic                   toggle_o
`endif
);

   localparam logic [P_DIV_WIDTH-1:0] RESET_DIV = P_DIV_WIDTH'(P_RESET_DIV);
   localparam logic [P_DIV_WIDTH-1:0] CNT_ONE   = P_DIV_WIDTH'(1);

   ceb_state_e             state_q, state_d;
   logic [P_DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [P_DIV_WIDTH-1:0] div_act_q, div_act_d;
   logic [P_DIV_WIDTH-1:0] div_pend_q, div_pend_d;
   logic                   pend_q, pend_d;
   logic                   tick_q, tick_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_act_d  = div_act_q;
      div_pend_d = div_pend_q;
      pend_d     = pend_q;
      tick_d     = 1'b0;

      if (!en_i) begin
         // Disabling drops any pending divisor; a write seen now behaves
         // like a write to an idle channel.
         state_d = CEB_OFF;
         cnt_d   = '0;
         pend_d  = 1'b0;
         if (wr_i) begin
            div_act_d = div_i;
         end
      end else begin
         case (state_q)
            CEB_OFF: begin
               state_d = CEB_SYNC;
               cnt_d   = '0;
               if (wr_i) begin
                  div_act_d = div_i;
               end
            end
            CEB_SYNC, CEB_LOCK: begin
               // cnt never exceeds div_act: div_act only changes while
               // cnt is 0, so the increment below cannot overflow.
               if (cnt_q == div_act_q) begin
                  tick_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = CEB_LOCK;
                  if (pend_q) begin
                     div_act_d = div_pend_q;
                     pend_d    = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
               // Placed after the wrap so a write on the wrap edge stays
               // pending for the following wrap; last write wins.
               if (wr_i) begin
                  div_pend_d = div_i;
                  pend_d     = 1'b1;
               end
            end
            default: begin
               state_d = CEB_OFF;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= CEB_OFF;
         cnt_q      <= '0;
         div_act_q  <= RESET_DIV;
         div_pend_q <= RESET_DIV;
         pend_q     <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_act_q  <= div_act_d;
         div_pend_q <= div_pend_d;
         pend_q     <= pend_d;
         tick_q     <= tick_d;
      end
   end

   assign tick_o    = tick_q;
   assign locked_o  = (state_q == CEB_LOCK);
   assign pending_o = pend_q;
   assign active_o  = (state_q != CEB_OFF);

`ifdef CLOCK_ENABLE_BANK_TOGGLE_EN
   logic toggle_q, toggle_d;

   always_comb begin
      toggle_d = 1'b0;
      if (state_d != CEB_OFF) begin
         toggle_d = toggle_q ^ tick_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         toggle_q <= 1'b0;
      end else begin
         toggle_q <= toggle_d;
      end
   end

   assign toggle_o = toggle_q;
`endif

endmodule

// File: rtl/clock_enable_bank.sv
// rtl/clock_enable_bank.sv - bank of programmable clock-enable tick channels
// Purpose: decodes divisor writes to P_CHANNELS clock_enable_channel
//          instances and reduces the all-locked indication. Optional
//          square-wave outputs with macro CLOCK_ENABLE_BANK_TOGGLE_EN.
// Ports:   iCLOCK, iRESET          clock, asynchronous active-high reset
//          iCONF_REQ/CH/DIV        single-cycle divisor write
//          iCH_EN                  per-channel run enable
//          oTICK, oLOCKED          per-channel tick and lock
//          oPENDING                per-channel divisor write pending
//          oALL_LOCKED             some channel enabled and all enabled locked
//          oTOGGLE                 per-channel square wave (macro only)
module clock_enable_bank
   import clock_enable_pkg::*;
#(
   parameter int          P_CHANNELS  = 4,
   parameter int          P_DIV_WIDTH = 16,
   parameter int unsigned P_RESET_DIV = 0
)
(
   input  logic                                iCLOCK,
   input  logic                                iRESET,
   input  logic                                iCONF_REQ,
   input  logic [ceb_ch_width(P_CHANNELS)-1:0] iCONF_CH,
   input  logic [P_DIV_WIDTH-1:0]              iCONF_DIV,
   input  logic [P_CHANNELS-1:0]               iCH_EN,
   output logic [P_CHANNELS-1:0]               oTICK,
   output logic [P_CHANNELS-1:0]               oLOCKED,
   output logic [P_CHANNELS-1:0]               oPENDING,
   output logic                                oALL_LOCKED
`ifdef CLOCK_ENABLE_BANK_TOGGLE_EN
   ,
   output logic [P_CHANNELS-1:0]               oTOGGLE
`endif
);

   localparam int CW = ceb_ch_width(P_CHANNELS);

   if (P_CHANNELS < CEB_MIN_CHANNELS || P_CHANNELS > CEB_MAX_CHANNELS) begin : g_bad_channels
      $error("clock_enable_bank: P_CHANNELS out of range");
   end
   if (P_DIV_WIDTH < CEB_MIN_DIV_WIDTH || P_DIV_WIDTH > CEB_MAX_DIV_WIDTH) begin : g_bad_width
      $error("clock_enable_bank: P_DIV_WIDTH out of range");
   end

   logic [P_CHANNELS-1:0] locked;
   logic [P_CHANNELS-1:0] active;
   logic                  all_locked_q, all_locked_d;

   // Indices >= P_CHANNELS match no channel, so such writes are dropped.
   for (genvar g = 0; g < P_CHANNELS; g++) begin : g_ch
      localparam logic [CW-1:0] CH_IDX = CW'(g);
      logic wr;

      assign wr = iCONF_REQ && (iCONF_CH == CH_IDX);

      clock_enable_channel #(
         .P_DIV_WIDTH (P_DIV_WIDTH),
         .P_RESET_DIV (P_RESET_DIV)
      ) u_ch (
         .clk_i     (iCLOCK),
         .rst_i     (iRESET),
         .en_i      (iCH_EN[g]),
         .wr_i      (wr),
         .div_i     (iCONF_DIV),
         .tick_o    (oTICK[g]),
         .locked_o  (locked[g]),
         .pending_o (oPENDING[g]),
         .active_o  (active[g])
`ifdef CLOCK_ENABLE_BANK_TOGGLE_EN
         ,
         .toggle_o  (oTOGGLE[g])
`endif
      );
   end

   // Built from registered channel state, hence the one-cycle lag.
   assign all_locked_d = (|active) && (&(locked | ~active));

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         all_locked_q <= 1'b0;
      end else begin
         all_locked_q <= all_locked_d;
      end
   end

   assign oLOCKED     = locked;
   assign oALL_LOCKED = all_locked_q;

endmodule

// File: tb/tb_clock_enable_bank.sv
// tb/tb_clock_enable_bank.sv - directed self-checking bench for clock_enable_bank
module tb_clock_enable_bank;

   localparam int NCH = 3;
   localparam int W   = 8;
   localparam int RD  = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic           conf_req;
   logic [1:0]     conf_ch;
   logic [W-1:0]   conf_div;
   logic [NCH-1:0] ch_en;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] locked;
   logic [NCH-1:0] pending;
   logic           all_locked;
`ifdef CLOCK_ENABLE_BANK_TOGGLE_EN
   logic [NCH-1:0] toggle;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int n_cyc;

   logic [63:0] cap_tick, cap_lock, cap_pend, cap_all, cap_tog;

   always #5 clk = ~clk;

   clock_enable_bank #(
      .P_CHANNELS  (NCH),
      .P_DIV_WIDTH (W),
      .P_RESET_DIV (RD)
   ) dut (
      .iCLOCK      (clk),
      .iRESET      (rst),
      .iCONF_REQ   (conf_req),
      .iCONF_CH    (conf_ch),
      .iCONF_DIV   (conf_div),
      .iCH_EN      (ch_en),
      .oTICK       (tick),
      .oLOCKED     (locked),
      .oPENDING    (pending),
      .oALL_LOCKED (all_locked)
`ifdef CLOCK_ENABLE_BANK_TOGGLE_EN
      ,
      .oTOGGLE     (toggle)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bit k of each capture vector holds the output after the (k+1)-th edge;
   // any write strobe set up beforehand lasts exactly one edge.
   task automatic capture(input int ch, input int n);
      cap_tick = '0; cap_lock = '0; cap_pend = '0; cap_all = '0; cap_tog = '0;
      for (int k = 0; k < n; k++) begin
         step();
         conf_req = 1'b0;
         cap_tick[k] = tick[ch];
         cap_lock[k] = locked[ch];
         cap_pend[k] = pending[ch];
         cap_all[k]  = all_locked;
`ifdef CLOCK_ENABLE_BANK_TOGGLE_EN
         cap_tog[k]  = toggle[ch];
`endif
      end
   endtask

   task automatic write(input logic [1:0] ch, input logic [W-1:0] div);
      conf_req = 1'b1;
      conf_ch  = ch;
      conf_div = div;
      step();
      conf_req = 1'b0;
   endtask

   task automatic wait_tick(input int ch, input int limit, output int cycles);
      cycles = -1;
      for (int i = 1; i <= limit; i++) begin
         step();
         if (tick[ch]) begin
            cycles = i;
            break;
         end
      end
   endtask

   initial begin
      rst = 1'b1; conf_req = 1'b0; conf_ch = '0; conf_div = '0; ch_en = '0;
      step(); step();
      chk("reset_tick", 64'(tick), 64'h0);
      chk("reset_locked", 64'(locked), 64'h0);
      chk("reset_pending", 64'(pending), 64'h0);
      chk("reset_all_locked", 64'(all_locked), 64'h0);
      rst = 1'b0;
      step();

      // Channel 0, D=4: ticks 5, 10, 15 cycles after the enable edge
      write(2'd0, 8'd4);
      chk("off_write_not_pending", 64'(pending), 64'h0);
      ch_en = 3'b001;
      step();
      chk("d4_tick_at_enable", 64'(tick[0]), 64'h0);
      chk("d4_lock_at_enable", 64'(locked[0]), 64'h0);
      capture(0, 16);
      chk("d4_ticks", cap_tick, 64'h4210);
      chk("d4_locks", cap_lock, 64'hFFF0);
      ch_en = 3'b000;
      step(); step();
      chk("disable_tick", 64'(tick[0]), 64'h0);
      chk("disable_locked", 64'(locked[0]), 64'h0);

      // Channel 1, D=3 then D=7 mid-period
      write(2'd1, 8'd3);
      ch_en = 3'b010;
      step();
      step(); step();
      conf_req = 1'b1; conf_ch = 2'd1; conf_div = 8'd7;
      capture(1, 20);
      chk("d3to7_ticks", cap_tick, 64'h20202);
      chk("d3to7_pending", cap_pend, 64'h1);
      chk("d3to7_lock_held", cap_lock, 64'hFFFFE);

      // Two writes in one period (last wins) plus a write to channel 3
      write(2'd1, 8'd9);
      write(2'd1, 8'd2);
      write(2'd3, 8'd0);
      chk("two_writes_pending", 64'(pending), 64'h2);
      capture(1, 12);
      chk("last_write_wins_ticks", cap_tick, 64'h924);
      chk("last_write_wins_pend", cap_pend, 64'h3);
      ch_en = 3'b000;
      step(); step();
      chk("all_off_tick", 64'(tick), 64'h0);
      chk("all_off_locked", 64'(locked), 64'h0);

      // D=0: continuous tick
      write(2'd0, 8'd0);
      ch_en = 3'b001;
      step();
      capture(0, 8);
      chk("d0_ticks", cap_tick, 64'hFF);
      ch_en = 3'b000;
      step(); step();

      // D=2^W-1 on channel 2: period 2^W
      write(2'd2, 8'd255);
      ch_en = 3'b100;
      step();
      wait_tick(2, 300, n_cyc);
      chk("dmax_first_tick", 64'(n_cyc), 64'd256);
      wait_tick(2, 300, n_cyc);
      chk("dmax_period", 64'(n_cyc), 64'd256);
      ch_en = 3'b000;
      step(); step();

      // All-locked reduction
      write(2'd0, 8'd1);
      write(2'd2, 8'd6);
      chk("all_locked_idle", 64'(all_locked), 64'h0);
      ch_en = 3'b101;
      step();
      capture(2, 10);
      chk("ch2_lock", cap_lock, 64'h3C0);
      chk("all_locked_rise", cap_all, 64'h380);
      ch_en = 3'b001;
      step(); step();
      chk("all_locked_ch2_off", 64'(all_locked), 64'h1);
      ch_en = 3'b000;
      step(); step();
      chk("all_locked_none", 64'(all_locked), 64'h0);

      // Asynchronous reset with a write pending
      ch_en = 3'b011;
      step(); step(); step();
      write(2'd1, 8'd50);
      chk("pend_before_reset", 64'(pending), 64'h2);
      #2 rst = 1'b1;
      #1;
      chk("async_reset_tick", 64'(tick), 64'h0);
      chk("async_reset_locked", 64'(locked), 64'h0);
      chk("async_reset_pending", 64'(pending), 64'h0);
      chk("async_reset_all", 64'(all_locked), 64'h0);
      ch_en = 3'b000;
      step();
      rst = 1'b0;
      ch_en = 3'b010;
      step();
      capture(1, 6);
      chk("reset_div_ticks", cap_tick, 64'h08);
      chk("reset_div_pend", cap_pend, 64'h0);

`ifdef CLOCK_ENABLE_BANK_TOGGLE_EN
      ch_en = 3'b000;
      step(); step();
      chk("toggle_off", 64'(toggle), 64'h0);
      write(2'd0, 8'd2);
      ch_en = 3'b001;
      step();
      capture(0, 12);
      chk("toggle_d2", cap_tog, 64'h71C);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
